cluster_expander384: RTL

Reconstructs a 384-strip hit map from the stream of encoded clusters (address, count, valid) that the cluster priority-encoding chain produces. It sits at the receiving end of the cluster link and serves loopback checking and occupancy monitoring. Clusters arrive one per clock, grouped into bunch-crossing frames. The block accumulates each frame's clusters into a working mask, then publishes the finished mask with a one-cycle valid strobe and per-frame status.

---
 rtl/cluster_expander384_pkg.sv | 15 +
 rtl/cluster_expander384_span.sv | 27 ++
 rtl/cluster_expander384.sv | 117 +++++++++++
 3 files changed

// File: rtl/cluster_expander384_pkg.sv
// Shared widths and types for the cluster encoder/expander pair.
package cluster_expander384_pkg;

    localparam int MXKEYS    = 384;  // strips per map
    localparam int MXKEYBITS = 9;    // cluster address width
    localparam int MXCNTB    = 3;    // cluster count width (span = cnt+1)
    localparam int MXCLST    = 8;    // clusters accepted per frame
    localparam int NCLB      = 4;    // width of the per-frame cluster counter

    typedef enum logic {
        ST_IDLE  = 1'b0,   // nothing received in this frame, working mask zero
        ST_ACCUM = 1'b1    // at least one cluster received in this frame
    } exp_state_t;

endpackage

// File: rtl/cluster_expander384_span.sv
// Combinational span decoder: (adr, cnt) -> clipped strip mask + bad address flag.
module cluster_span_decoder
    import cluster_expander384_pkg::*;
(
    input  logic [MXKEYBITS-1:0] adr_i,
    input  logic [MXCNTB-1:0]    cnt_i,
    output logic [MXKEYS-1:0]    span_o,
    output logic                 bad_adr_o
);

    // One extra bit so adr+cnt never wraps; the strip loop stops at 383 which clips.
    logic [MXKEYBITS:0] hi;

    assign bad_adr_o = (adr_i >= MXKEYBITS'(MXKEYS));
    assign hi        = {1'b0, adr_i} + (MXKEYBITS+1)'(cnt_i);

    // Set every strip between adr and adr+cnt, nothing for an invalid address.
    always_comb begin
        span_o = '0;
        for (int i = 0; i < MXKEYS; i++) begin
            if (!bad_adr_o && ((MXKEYBITS+1)'(i) >= {1'b0, adr_i}) && ((MXKEYBITS+1)'(i) <= hi)) begin
                span_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cluster_expander384.sv
// Rebuilds a 384-strip hit map per frame from the encoded cluster stream.
// Stream semantics: vpf qualifies adr/cnt for one cycle, no backpressure;
// last closes the frame, and mask_valid strobes for one cycle one clock later.
module cluster_expander384
    import cluster_expander384_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 vpf,
    input  logic [MXKEYBITS-1:0] adr,
    input  logic [MXCNTB-1:0]    cnt,
    input  logic                 last,
    output logic [MXKEYS-1:0]    mask_out,
    output logic                 mask_valid,
    output logic [NCLB-1:0]      nclusters,
    output logic                 overflow,
    output logic                 bad_adr,
    output exp_state_t           state_o
);

    logic [MXKEYS-1:0] span;
    logic              span_bad;

    cluster_span_decoder u_span (
        .adr_i     (adr),
        .cnt_i     (cnt),
        .span_o    (span),
        .bad_adr_o (span_bad)
    );

    exp_state_t        state_q, state_d;
    logic              publish;
    logic [MXKEYS-1:0] work_q, work_d;
    logic [NCLB-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              bad_q, bad_d;
    logic              take;
    logic              drop;

    logic [MXKEYS-1:0] mask_q;
    logic              valid_q;
    logic [NCLB-1:0]   ncl_q;
    logic              ovf_out_q;
    logic              bad_out_q;

    // A valid in-range cluster is taken unless the frame already holds MXCLST.
    assign take = vpf && !span_bad && (cnt_q != NCLB'(MXCLST));
    assign drop = vpf && !span_bad && (cnt_q == NCLB'(MXCLST));

    // Frame contents including this cycle's cluster (what a publish would show).
    always_comb begin
        work_d = work_q | (take ? span : '0);
        cnt_d  = cnt_q + (take ? NCLB'(1) : NCLB'(0));
        ovf_d  = ovf_q | drop;
        bad_d  = bad_q | (vpf && span_bad);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: any cluster opens a frame, last always returns to idle.
    always_comb begin
        state_d = state_q;
        if (last)     state_d = ST_IDLE;
        else if (vpf) state_d = ST_ACCUM;
    end

    // Output decode: publish on every last, whatever the state.
    always_comb begin
        publish = last;
    end

    // Working mask, counter and flags; cleared by a publish.
    always_ff @(posedge clock) begin
        if (reset || publish) begin
            work_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            bad_q  <= bad_d;
        end
    end

    // Published outputs hold until the next publish; the strobe lasts one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q    <= '0;
            valid_q   <= 1'b0;
            ncl_q     <= '0;
            ovf_out_q <= 1'b0;
            bad_out_q <= 1'b0;
        end else begin
            valid_q <= publish;
            if (publish) begin
                mask_q    <= work_d;
                ncl_q     <= cnt_d;
                ovf_out_q <= ovf_d;
                bad_out_q <= bad_d;
            end
        end
    end

    assign mask_out   = mask_q;
    assign mask_valid = valid_q;
    assign nclusters  = ncl_q;
    assign overflow   = ovf_out_q;
    assign bad_adr    = bad_out_q;
    assign state_o    = state_q;

endmodule
